pipe_adder: RTL and testbench



---
 rtl/pipe_adder_if.sv | 49 ++++
 rtl/pipe_adder.sv | 155 +++++++++++++++
 tb/tb_pipe_adder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: valid/ready bundle carrying one addition request and its result.
//
// Parameters:
//   WIDTH : operand and sum width in bits.
// Signals:
//   a, b, cin, in_valid  : request side, driven by the master.
//   in_ready             : request accept, driven by the slave (the adder).
//   sum, cout, overflow  : result payload, driven by the slave.
//   out_valid            : result valid, driven by the slave.
//   out_ready            : result accept, driven by the master.
//   sub                  : subtract request, present only when PIPE_ADDER_SUB_EN is defined.
// Modports:
//   master : producer/consumer surrounding the adder.
//   slave  : the adder itself.
interface pipe_adder_if #(
  parameter int unsigned WIDTH = 32
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;
`ifdef PIPE_ADDER_SUB_EN
  logic             sub;
`endif

  modport master (
`ifdef PIPE_ADDER_SUB_EN
    output sub,
`endif
    output a, b, cin, in_valid, out_ready,
    input  in_ready, sum, cout, overflow, out_valid
  );

  modport slave (
`ifdef PIPE_ADDER_SUB_EN
    input  sub,
`endif
    input  a, b, cin, in_valid, out_ready,
    output in_ready, sum, cout, overflow, out_valid
  );

endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit two's-complement adder with valid/ready on both sides.
//
// The operands are split into STAGES equal chunks of C = WIDTH/STAGES bits. Stage k adds
// chunk k plus the carry registered by stage k-1, so the carry ripples register to register.
// One operation per cycle; the result of an op presented in cycle n is valid STAGES cycles
// later (the accept edge loads stage 0, each further edge moves it one stage on).
//
// Parameters:
//   WIDTH  : operand/sum width (default 32).
//   STAGES : pipeline depth, 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0 (default 4).
// Ports:
//   clk    : clock, all state on the rising edge.
//   rst    : synchronous active-high reset; clears valids and the result registers.
//   bus_io : pipe_adder_if slave modport (a, b, cin, in_valid, in_ready, sum, cout,
//            overflow, out_valid, out_ready, and sub when enabled).
// Build option:
//   PIPE_ADDER_SUB_EN : adds bus_io.sub; sub = 1 computes a + ~b + 1 and ignores cin.
module pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic         clk,
  input logic         rst,
  pipe_adder_if.slave bus_io
);

  localparam int unsigned C  = WIDTH / STAGES;
  localparam int unsigned CW = C + 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipe_adder: STAGES must divide WIDTH and lie in 1..WIDTH");
  end

  // Stage valids and handshake
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] adv;
  logic              accept;

  // Stage payload: sum bits done so far, operands still to add, carries
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] cmsb_q;

  // Stage 0 operand conditioning
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;

`ifdef PIPE_ADDER_SUB_EN
  // a - b == a + ~b + 1; cin is ignored while subtracting.
  assign b_eff   = bus_io.sub ? ~bus_io.b : bus_io.b;
  assign cin_eff = bus_io.sub | bus_io.cin;
`else
  assign b_eff   = bus_io.b;
  assign cin_eff = bus_io.cin;
`endif

  // A stage moves on when anything downstream of it has room: an empty stage
  // further along, or the consumer taking the result this cycle.
  always_comb begin : p_adv
    logic room;
    room = bus_io.out_ready;
    adv  = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      adv[k] = v_q[k] & room;
      room   = room | ~v_q[k];
    end
  end

  assign bus_io.in_ready = ~rst & (~v_q[0] | adv[0]);
  assign accept          = bus_io.in_valid & bus_io.in_ready;

  always_comb begin
    v_d = v_q;
    if (accept) begin
      v_d[0] = 1'b1;
    end else if (adv[0]) begin
      v_d[0] = 1'b0;
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (adv[k-1]) begin
        v_d[k] = 1'b1;
      end else if (adv[k]) begin
        v_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] s_d;
    logic             c_in;
    logic             load;
    logic [C:0]       chunk;

    if (k == 0) begin : g_head
      assign op_a = bus_io.a;
      assign op_b = b_eff;
      assign c_in = cin_eff;
      assign part = '0;
      assign load = accept;
    end else begin : g_body
      assign op_a = a_q[k-1];
      assign op_b = b_q[k-1];
      assign c_in = carry_q[k-1];
      assign part = s_q[k-1];
      assign load = adv[k-1];
    end

    assign chunk = {1'b0, op_a[k*C +: C]} + {1'b0, op_b[k*C +: C]} + CW'(c_in);

    always_comb begin
      s_d             = part;
      s_d[k*C +: C]   = chunk[C-1:0];
    end

    // Payload only moves on load; an emptied stage keeps stale data.
    always_ff @(posedge clk) begin
      if (rst) begin
        s_q[k]     <= '0;
        carry_q[k] <= 1'b0;
        cmsb_q[k]  <= 1'b0;
      end else if (load) begin
        s_q[k]     <= s_d;
        a_q[k]     <= op_a;
        b_q[k]     <= op_b;
        carry_q[k] <= chunk[C];
        // Carry into the chunk MSB recovered from its sum bit: s = a ^ b ^ c.
        cmsb_q[k]  <= chunk[C-1] ^ op_a[k*C + C - 1] ^ op_b[k*C + C - 1];
      end
    end
  end

  // Last-stage operand copies and non-final MSB carries have no reader.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], cmsb_q};

  assign bus_io.out_valid = v_q[STAGES-1];
  assign bus_io.sum       = s_q[STAGES-1];
  assign bus_io.cout      = carry_q[STAGES-1];
  assign bus_io.overflow  = carry_q[STAGES-1] ^ cmsb_q[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: self-checking bench for pipe_adder (WIDTH 32, STAGES 4).
// Directed vector table, hand-written streaming / back-pressure / reset sequences, and a
// randomized run scored against an arithmetic model through an expected-result queue.
module tb_pipe_adder;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  typedef struct packed {
    logic         ovf;
    logic         cout;
    logic [W-1:0] sum;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic cur_sub = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(W)) bus ();

  pipe_adder #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    longint          sa;
    longint          sb;
    longint          sr;
    longint unsigned ur;
    res_t            r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      sr     = sa - sb;
      r.sum  = a - b;
      r.cout = (a >= b);
    end else begin
      sr     = sa + sb + longint'(cin);
      ur     = longint'({32'b0, a}) + longint'({32'b0, b}) + longint'({63'b0, cin});
      r.sum  = ur[W-1:0];
      r.cout = ur[W];
    end
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input logic valid);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = valid;
    cur_sub      = sub;
`ifdef PIPE_ADDER_SUB_EN
    bus.sub      = sub;
`endif
  endtask

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return '0;
      default: return $urandom();
    endcase
  endfunction

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: handshakes sampled mid-cycle take effect at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(bus.out_valid), 64'd0);
        end else begin
          check("model_result", 64'({bus.overflow, bus.cout, bus.sum}), 64'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.cin, cur_sub));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    vec_t         vecs[$];
    int           lat;
    logic         got;
    int           acc;
    int           n_seen;
    int           seen_at[8];
    logic [W-1:0] seen_val[8];
    res_t         r0;
    logic         rs;

    drive('0, '0, 1'b0, 1'b0, 1'b1);
    bus.out_ready = 1'b1;

    vecs.push_back('{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0});
`ifdef PIPE_ADDER_SUB_EN
    vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0});
`endif

    // Reset held with in_valid high
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready_2", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_release_out_valid", 64'(bus.out_valid), 64'd0);

    // Directed vectors, one at a time, latency measured from the presenting cycle
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1);
      @(negedge clk);
      check("vec_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      got = 1'b0;
      while (!got && lat <= 12) begin
        @(negedge clk);
        if (bus.out_valid) got = 1'b1;
        else lat++;
      end
      check("vec_latency", 64'(lat), 64'(S));
      check("vec_result", 64'({bus.overflow, bus.cout, bus.sum}),
            64'({vecs[i].ovf, vecs[i].cout, vecs[i].sum}));
    end

    // Streaming: 8 back-to-back ops, results on consecutive cycles
    n_seen = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c < 8) drive(32'(c), 32'(3 * c), 1'(c & 1), 1'b0, 1'b1);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (c < 8) check("stream_in_ready", 64'(bus.in_ready), 64'd1);
      if (bus.out_valid && n_seen < 8) begin
        seen_at[n_seen]  = c;
        seen_val[n_seen] = bus.sum;
        n_seen++;
      end
    end
    check("stream_count", 64'(n_seen), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check("stream_cycle", 64'(seen_at[i]), 64'(i + 4));
      check("stream_value", 64'(seen_val[i]), 64'(4 * i + (i & 1)));
    end

    // Back-pressure: out_ready low for 6 cycles while streaming
    r0  = model(32'h1111_1111, 32'hF0F0_F0F0, 1'b1, 1'b0);
    acc = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      drive(32'(32'h1111_1111 * (acc + 1)), 32'hF0F0_F0F0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      if (j < 4) begin
        check("bp_in_ready_high", 64'(bus.in_ready), 64'd1);
      end else begin
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_hold", 64'({bus.overflow, bus.cout, bus.sum}), 64'(r0));
      end
      if (bus.in_ready) acc++;
    end
    check("bp_accepts", 64'(acc), 64'd4);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain("bp_drain");

    // Reset with ops in flight: none may surface
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst_flush_sum", 64'(bus.sum), 64'd0);
    for (int j = 0; j < 8; j++) begin
      check("rst_flush_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rs = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      drive(rand_word(), rand_word(), 1'($urandom_range(0, 1)), rs,
            ($urandom_range(0, 3) != 0));
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
